// File: rtl/memaccess_dmem_responder_pkg.sv
// Purpose: shared types and widths for the memaccess data-memory responder.
// Latency: n/a (types only).
// Backpressure: n/a; the bus has no flow control, accesses are single-cycle samples.
package memaccess_dmem_pkg;

    localparam int DATA_W = 16;

    // Bus phase driven by the MemAccess initiator.
    typedef enum logic [1:0] {
        MS_READ     = 2'b00,
        MS_WRITE    = 2'b01,
        MS_INDIRECT = 2'b10,
        MS_IDLE     = 2'b11
    } mem_state_t;

    // Responder control: CLEAR after reset, RUN once every word is initialised.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } dmem_fsm_t;

endpackage

// File: rtl/memaccess_dmem_responder_if.sv
// Purpose: bundle of memaccess bus signals between initiator (master) and memory (slave).
// Latency: n/a (wiring only).
// Backpressure: none on the bus; busy tells the initiator accesses are being ignored.
// Ports: MControl/MAddr/MData/mem_state from master; DMem_out/busy/addr_err from slave.
interface memaccess_dmem_responder_if;
    import memaccess_dmem_pkg::*;

    logic              MControl;
    logic [DATA_W-1:0] MAddr;
    logic [DATA_W-1:0] MData;
    mem_state_t        mem_state;
    logic [DATA_W-1:0] DMem_out;
    logic              busy;
    logic              addr_err;

    modport master (
        output MControl, MAddr, MData, mem_state,
        input  DMem_out, busy, addr_err
    );

    modport slave (
        input  MControl, MAddr, MData, mem_state,
        output DMem_out, busy, addr_err
    );

endinterface

// File: rtl/memaccess_dmem_rdpipe.sv
// Purpose: LAT-deep data/valid shift register carrying read results toward DMem_out.
// Latency: LAT edges from in_* sample to out_*.
// Backpressure: none; shifts every edge, async active-low clear flushes all stages.
// Ports: clk_i, rst_ni, in_vld_i/in_dat_i (stage 1 input), out_vld_o/out_dat_o (stage LAT).
module memaccess_dmem_rdpipe #(
    parameter int LAT = 1,
    parameter int W   = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_vld_i,
    input  logic [W-1:0] in_dat_i,
    output logic         out_vld_o,
    output logic [W-1:0] out_dat_o
);

    logic [LAT-1:0] vld_q;
    logic [W-1:0]   dat_q [LAT];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_vld_i;
            dat_q[0] <= in_dat_i;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign out_vld_o = vld_q[LAT-1];
    assign out_dat_o = dat_q[LAT-1];

endmodule

// File: rtl/memaccess_dmem_responder.sv
// Purpose: word-addressed data memory for the MemAccess stage with post-reset self-clear.
// Latency: READ_LATENCY edges from address sample to DMem_out; writes land at the sample edge.
// Backpressure: none; while busy (clearing) every bus access is silently dropped.
// Ports: clock, reset (async active-low), bus (slave modport of memaccess_dmem_responder_if).
module memaccess_dmem_responder
    import memaccess_dmem_pkg::*;
#(
    parameter int                DEPTH        = 256,
    parameter int                READ_LATENCY = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE   = 16'h0000
) (
    input  logic                         clock,
    input  logic                         reset,
    memaccess_dmem_responder_if.slave    bus
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [0:0] ST_CLEAR = CLEAR;
    localparam logic [0:0] ST_RUN   = RUN;

    logic [0:0]        state_q, state_d;
    logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0] dmem_out_q;
    logic              addr_err_q, addr_err_d;

    // No reset on the array so it maps onto RAM; the CLEAR walk initialises it.
    logic [DATA_W-1:0] mem [DEPTH];

    logic              run;
    logic [AW-1:0]     idx;
    logic              oob;
    logic              wr_req;
    logic              rd_req;
    logic [DATA_W-1:0] rd_dat;
    logic              pipe_vld;
    logic [DATA_W-1:0] pipe_dat;

    assign run = (state_q == ST_RUN);
    assign idx = bus.MAddr[AW-1:0];
    // Upper bits are checked rather than truncated so no address aliases.
    assign oob = |bus.MAddr[DATA_W-1:AW];

    assign wr_req = run && (bus.mem_state == MS_WRITE) && bus.MControl;
    assign rd_req = run && ((bus.mem_state == MS_READ) || (bus.mem_state == MS_INDIRECT))
                        && !bus.MControl;

    // Out-of-range reads still occupy a pipeline slot, returning zero.
    assign rd_dat = oob ? '0 : mem[idx];

    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        addr_err_d = (wr_req || rd_req) && oob;
        if (state_q == ST_CLEAR) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == AW'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_CLEAR;
            clr_ptr_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!run) begin
            mem[clr_ptr_q] <= INIT_VALUE;
        end else if (wr_req && !oob) begin
            mem[idx] <= bus.MData;
        end
    end

    memaccess_dmem_rdpipe #(
        .LAT (READ_LATENCY),
        .W   (DATA_W)
    ) u_rdpipe (
        .clk_i     (clock),
        .rst_ni    (reset),
        .in_vld_i  (rd_req),
        .in_dat_i  (rd_dat),
        .out_vld_o (pipe_vld),
        .out_dat_o (pipe_dat)
    );

    // DMem_out holds between reads; only a valid pipeline exit updates it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dmem_out_q <= '0;
        end else if (pipe_vld) begin
            dmem_out_q <= pipe_dat;
        end
    end

    assign bus.DMem_out = dmem_out_q;
    assign bus.busy     = !run;
    assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_memaccess_dmem_responder.sv
// Purpose: self-checking bench for memaccess_dmem_responder at READ_LATENCY 1 and 3.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_memaccess_dmem_responder;
    import memaccess_dmem_pkg::*;

    localparam int DEPTH = 256;
    localparam int LAT [2] = '{1, 3};
    localparam logic [15:0] INITV [2] = '{16'h0000, 16'hA5C3};

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        drv_ctl  = 1'b0;
    logic [15:0] drv_addr = '0;
    logic [15:0] drv_data = '0;
    logic [1:0]  drv_ms   = 2'b11;

    memaccess_dmem_responder_if b1 ();
    memaccess_dmem_responder_if b3 ();

    assign b1.MControl  = drv_ctl;
    assign b1.MAddr     = drv_addr;
    assign b1.MData     = drv_data;
    assign b1.mem_state = mem_state_t'(drv_ms);
    assign b3.MControl  = drv_ctl;
    assign b3.MAddr     = drv_addr;
    assign b3.MData     = drv_data;
    assign b3.mem_state = mem_state_t'(drv_ms);

    memaccess_dmem_responder #(.DEPTH(DEPTH), .READ_LATENCY(1), .INIT_VALUE(16'h0000)) u_dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (b1)
    );

    memaccess_dmem_responder #(.DEPTH(DEPTH), .READ_LATENCY(3), .INIT_VALUE(16'hA5C3)) u_dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (b3)
    );

    // Reference model: per-DUT word array, clear progress, and a history of
    // read results indexed by sampling edge (each DUT looks LAT edges back).
    logic [15:0] mm [2][DEPTH];
    int          m_ptr;
    bit          m_busy;
    bit          m_err;
    logic [15:0] m_out [2];
    bit          hv [8];
    logic [15:0] hd [2][8];
    int          e_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_busy = 1'b1;
        m_err  = 1'b0;
        for (int d = 0; d < 2; d++) m_out[d] = '0;
        for (int s = 0; s < 8; s++) hv[s] = 1'b0;
    endtask

    task automatic model_edge();
        bit wr, rd, oob;
        e_cnt++;
        for (int d = 0; d < 2; d++) begin
            if (hv[(e_cnt - LAT[d]) & 7]) m_out[d] = hd[d][(e_cnt - LAT[d]) & 7];
        end
        hv[e_cnt & 7] = 1'b0;
        m_err = 1'b0;
        if (m_busy) begin
            for (int d = 0; d < 2; d++) mm[d][m_ptr] = INITV[d];
            m_ptr++;
            if (m_ptr == DEPTH) m_busy = 1'b0;
        end else begin
            wr  = (drv_ms == 2'b01) && drv_ctl;
            rd  = (drv_ms == 2'b00 || drv_ms == 2'b10) && !drv_ctl;
            oob = (drv_addr >= 16'(DEPTH));
            if (rd) begin
                hv[e_cnt & 7] = 1'b1;
                for (int d = 0; d < 2; d++) hd[d][e_cnt & 7] = oob ? 16'h0000 : mm[d][drv_addr[7:0]];
            end
            if (wr && !oob) begin
                for (int d = 0; d < 2; d++) mm[d][drv_addr[7:0]] = drv_data;
            end
            m_err = (rd || wr) && oob;
        end
    endtask

    task automatic check_outputs();
        chk("busy_l1", 32'(b1.busy), 32'(m_busy));
        chk("busy_l3", 32'(b3.busy), 32'(m_busy));
        chk("addr_err_l1", 32'(b1.addr_err), 32'(m_err));
        chk("addr_err_l3", 32'(b3.addr_err), 32'(m_err));
        chk("dmem_out_l1", 32'(b1.DMem_out), 32'(m_out[0]));
        chk("dmem_out_l3", 32'(b3.DMem_out), 32'(m_out[1]));
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cyc(input logic ctl, input logic [15:0] addr, input logic [15:0] data,
                       input logic [1:0] ms);
        drv_ctl  = ctl;
        drv_addr = addr;
        drv_data = data;
        drv_ms   = ms;
        @(posedge clock);
        model_edge();
        #1;
        check_outputs();
        @(negedge clock);
    endtask

    task automatic rd(input logic [15:0] a);
        cyc(1'b0, a, 16'h0000, 2'b00);
    endtask
    task automatic rdi(input logic [15:0] a);
        cyc(1'b0, a, 16'h0000, 2'b10);
    endtask
    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        cyc(1'b1, a, d, 2'b01);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'(i), 16'hFFFF, 2'b11);
    endtask
    task automatic rnd_cyc();
        cyc(1'($urandom), 16'($urandom), 16'($urandom), 2'($urandom));
    endtask

    // Called at a falling edge: asynchronous assert between edges, release at a falling edge.
    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        chk("rst_dmem_l1", 32'(b1.DMem_out), 32'h0);
        chk("rst_dmem_l3", 32'(b3.DMem_out), 32'h0);
        chk("rst_busy", 32'(b1.busy & b3.busy), 32'h1);
        chk("rst_err", 32'(b1.addr_err | b3.addr_err), 32'h0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic wait_clear();
        int cnt;
        cnt = 0;
        while (cnt < 300) begin
            rnd_cyc();
            cnt++;
            if (!b1.busy) break;
        end
        chk("clear_len", 32'(cnt), 32'(DEPTH));
    endtask

    initial begin
        e_cnt = 0;
        model_reset();
        #1;
        chk("por_dmem", 32'(b1.DMem_out), 32'h0);
        chk("por_busy", 32'(b1.busy), 32'h1);
        chk("por_err", 32'(b1.addr_err), 32'h0);
        @(negedge clock);
        reset = 1'b1;

        wait_clear();

        // Freshly cleared words.
        rd(16'h0000); rd(16'h007F); rd(16'h00FF);
        idle(4);
        chk("cleared_l3", 32'(b3.DMem_out), 32'hA5C3);

        // Read-after-write.
        wr(16'h0010, 16'hBEEF);
        rd(16'h0010);
        idle(1);
        chk("raw_l1", 32'(b1.DMem_out), 32'hBEEF);
        idle(2);
        chk("raw_l3", 32'(b3.DMem_out), 32'hBEEF);

        // Back-to-back indirect reads, then idle holds.
        wr(16'h0001, 16'h1111); wr(16'h0002, 16'h2222); wr(16'h0003, 16'h3333);
        rdi(16'h0001); rdi(16'h0002); rdi(16'h0003);
        idle(5);
        chk("hold_l1", 32'(b1.DMem_out), 32'h3333);
        chk("hold_l3", 32'(b3.DMem_out), 32'h3333);

        // Out-of-range accesses.
        wr(16'h0100, 16'h5555);
        chk("oob_wr_err", 32'(b1.addr_err), 32'h1);
        rd(16'h0000);
        rd(16'h8000);
        chk("oob_rd_err", 32'(b1.addr_err), 32'h1);
        idle(4);

        // No-op combinations.
        cyc(1'b0, 16'h0010, 16'h0BAD, 2'b01);
        cyc(1'b1, 16'h0010, 16'h0BAD, 2'b00);
        cyc(1'b1, 16'h0010, 16'h0BAD, 2'b10);
        cyc(1'b1, 16'h0900, 16'h0BAD, 2'b11);
        rd(16'h0010);
        idle(4);

        // Randomised traffic, concentrated on a few addresses so reads hit writes.
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
            cyc(1'($urandom), a, 16'($urandom), 2'($urandom));
        end
        idle(4);

        // Reset while reads are in flight, then contents must be re-initialised.
        wr(16'h0020, 16'h1234);
        rd(16'h0020);
        rd(16'h0020);
        do_reset();
        wait_clear();
        rd(16'h0020);
        idle(3);
        chk("post_rst_l1", 32'(b1.DMem_out), 32'h0000);
        chk("post_rst_l3", 32'(b3.DMem_out), 32'hA5C3);

        // Reset in the middle of CLEAR.
        wr(16'h0030, 16'h7777);
        for (int i = 0; i < 3; i++) rd(16'h0030);
        do_reset();
        for (int i = 0; i < 100; i++) rnd_cyc();
        do_reset();
        wait_clear();
        rd(16'h0030);
        rd(16'h0010);
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
